// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, frame-format defaults
// and a small helper for sizing counters.
package uart_rx_pkg;

    // Default frame format: 8 data bits, 16 oversampling ticks of stop bit.
    localparam int NBIT_DATA_LEN_DEF = 8;
    localparam int SB_TICK_DEF       = 16;

    // Receiver FSM states, 2-bit encoding shared with the sibling UART blocks.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one start bit, configurable
// data length and stop length. Each frame is reported with a single-cycle
// rx_done_tick; dout and frame_err hold until the next completed frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NBIT_DATA_LEN = NBIT_DATA_LEN_DEF,
    parameter int SB_TICK       = SB_TICK_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_tick,
    input  logic                     rx,
    output logic                     rx_done_tick,
    output logic [NBIT_DATA_LEN-1:0] dout,
    output logic                     frame_err
);

    localparam int NW = cnt_width(NBIT_DATA_LEN);
    localparam logic [NW-1:0] N_LAST  = NW'(NBIT_DATA_LEN - 1);
    localparam logic [4:0]    SB_LAST = 5'(SB_TICK - 1);
    localparam logic [4:0]    MID_START = 5'd7;
    localparam logic [4:0]    BIT_LAST  = 5'd15;

    rx_state_e                state_q, state_d;
    logic [4:0]               s_cnt_q, s_cnt_d;
    logic [NW-1:0]            n_q, n_d;
    logic [NBIT_DATA_LEN-1:0] b_q, b_d;
    logic [NBIT_DATA_LEN-1:0] dout_q, dout_d;
    logic                     frame_err_q, frame_err_d;
    logic                     rx_done_tick_q, rx_done_tick_d;
    logic                     rx_meta_q, rx_meta_d;
    logic                     rx_s_q, rx_s_d;

    // Next-state logic: synchronizer shift plus the frame-decoding FSM.
    // Counters only move on s_tick outside IDLE, so a stalled baud
    // generator freezes the frame in place.
    always_comb begin
        rx_meta_d      = rx;
        rx_s_d         = rx_meta_q;
        state_d        = state_q;
        s_cnt_d        = s_cnt_q;
        n_d            = n_q;
        b_d            = b_q;
        dout_d         = dout_q;
        frame_err_d    = frame_err_q;
        rx_done_tick_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == MID_START) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        b_d     = {rx_s_q, b_q[NBIT_DATA_LEN-1:1]};
                        s_cnt_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        state_d        = IDLE;
                        rx_done_tick_d = 1'b1;
                        dout_d         = b_q;
                        frame_err_d    = ~rx_s_q;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame and
    // parks the synchronizer at the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            state_q        <= IDLE;
            s_cnt_q        <= '0;
            n_q            <= '0;
            b_q            <= '0;
            dout_q         <= '0;
            frame_err_q    <= 1'b0;
            rx_done_tick_q <= 1'b0;
        end else begin
            rx_meta_q      <= rx_meta_d;
            rx_s_q         <= rx_s_d;
            state_q        <= state_d;
            s_cnt_q        <= s_cnt_d;
            n_q            <= n_d;
            b_q            <= b_d;
            dout_q         <= dout_d;
            frame_err_q    <= frame_err_d;
            rx_done_tick_q <= rx_done_tick_d;
        end
    end

    assign rx_done_tick = rx_done_tick_q;
    assign dout         = dout_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit on
// the 16x tick grid, and a frame-level reference (data byte plus stop-bit
// level) predicts every rx_done_tick, dout and frame_err.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;

    logic       tick_en = 1'b1;
    logic [1:0] div = 2'd0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     got_q[$];
    logic [7:0] model_dout = 8'h00;
    logic       model_err  = 1'b0;

    uart_rx #(.NBIT_DATA_LEN(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
    );

    // 100 MHz-style clock.
    always #5 clk = ~clk;

    // Baud tick: one clk pulse every 4 clk while enabled.
    always @(posedge clk) begin
        div    <= div + 2'd1;
        s_tick <= tick_en && (div == 2'd3);
    end

    // Capture every cycle rx_done_tick is high, together with the outputs.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            got_q.push_back('{data: dout, err: frame_err});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait for n baud ticks; returns on the negedge of the n-th tick.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clk); while (s_tick !== 1'b1);
        end
    endtask

    // Send one frame: start bit, LSB-first data, stop bit of stop_ticks at
    // level stop_val, then idle_ticks of high line. pause_bit >= 0 stalls
    // the baud ticks for 100 clk in the middle of that data bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input int stop_ticks, input int idle_ticks,
                                 input int pause_bit);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == pause_bit) begin
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        rx = stop_val;
        wait_ticks(stop_ticks);
        rx = 1'b1;
        exp_q.push_back('{data: data, err: ~stop_val});
        model_dout = data;
        model_err  = ~stop_val;
        if (idle_ticks > 0) wait_ticks(idle_ticks);
    endtask

    // Compare captured frames against the reference, then check hold values.
    task automatic check_frames(input string tag);
        frame_t g;
        frame_t e;
        int     guard = 0;
        while (got_q.size() < exp_q.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checkOutput({tag, "_dout"}, 32'(g.data), 32'(e.data));
            checkOutput({tag, "_frame_err"}, 32'(g.err), 32'(e.err));
        end
        got_q.delete();
        exp_q.delete();
        checkOutput({tag, "_dout_hold"}, 32'(dout), 32'(model_dout));
        checkOutput({tag, "_err_hold"}, 32'(frame_err), 32'(model_err));
    endtask

    initial begin
        logic [7:0] rnd_data;
        logic       rnd_bad;

        $display("[TB] uart_rx bench start");

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_done", 32'(rx_done_tick), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_ticks(20);
        check_frames("idle");

        // Clean frame 0xA5.
        applyStimulus(8'hA5, 1'b1, 16, 8, -1);
        check_frames("a5");

        // Short low glitch: rejected, nothing reported, outputs held.
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(24);
        check_frames("glitch");

        // Stop bit sampled low: frame error, data still updated.
        applyStimulus(8'h5A, 1'b0, 10, 16, -1);
        check_frames("bad_stop");

        // Reset after four data bits of 0xFF, then a clean 0x3C.
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_ticks(16);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_done", 32'(rx_done_tick), 32'd0);
        checkOutput("midreset_dout", 32'(dout), 32'd0);
        checkOutput("midreset_err", 32'(frame_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_dout = 8'h00;
        model_err  = 1'b0;
        wait_ticks(96);
        check_frames("aborted");
        applyStimulus(8'h3C, 1'b1, 16, 8, -1);
        check_frames("after_reset");

        // Back-to-back frames with no idle gap.
        applyStimulus(8'h00, 1'b1, 16, 0, -1);
        applyStimulus(8'hFF, 1'b1, 16, 8, -1);
        check_frames("b2b");

        // Baud ticks stalled mid-data.
        applyStimulus(8'h96, 1'b1, 16, 8, 3);
        check_frames("pause");

        // Randomized frames, occasional bad stop bit, random idle gaps.
        for (int k = 0; k < 8; k++) begin
            rnd_data = 8'($urandom_range(0, 255));
            rnd_bad  = ($urandom_range(0, 3) == 0);
            if (rnd_bad) begin
                applyStimulus(rnd_data, 1'b0, 10, 16, -1);
            end else begin
                applyStimulus(rnd_data, 1'b1, 16, $urandom_range(0, 20), -1);
            end
            check_frames("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter NBIT_DATA_LEN, default 8: data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16: oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  one-clk enable pulse at 16x the baud rate, from the sibling baud generator.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_done_tick  output  1  one-clk pulse marking a completed frame.
REQ-008 dout  output  NBIT_DATA_LEN  last received data word; the downstream interface block samples it while rx_done_tick=1.
REQ-009 frame_err  output  1  stop bit of the last frame sampled low.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic below SHALL use the synchronized value rx_s only.
REQ-011 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-012 The FSM SHALL use a 5-bit tick counter s_cnt, a bit counter n of width clog2(NBIT_DATA_LEN), and a shift register b of NBIT_DATA_LEN bits.
REQ-013 IDLE: when rx_s=0, the FSM SHALL go to START with s_cnt=0, whether or not s_tick is asserted; otherwise s_tick is ignored.
REQ-014 START: on s_tick with s_cnt=7 (mid start bit), if rx_s=0 the FSM SHALL go to DATA with s_cnt=0 and n=0, else return to IDLE (glitch rejection); on other s_tick it SHALL increment s_cnt.
REQ-015 DATA: on s_tick with s_cnt=15, the FSM SHALL set b={rx_s, b[N-1:1]} (LSB first) and s_cnt=0; if n=NBIT_DATA_LEN-1 it SHALL go to STOP, else n SHALL increment; on other s_tick, s_cnt SHALL increment.
REQ-016 STOP: on s_tick with s_cnt=SB_TICK-1, the FSM SHALL go to IDLE, pulse rx_done_tick, load dout=b and set frame_err=~rx_s; on other s_tick, s_cnt SHALL increment.
REQ-017 rx_done_tick SHALL be registered and high for exactly one clk, in the cycle after the final STOP s_tick.
REQ-018 dout and frame_err SHALL hold their values until the next completed frame; a frame with an error SHALL still update dout.
REQ-019 Without s_tick in START, DATA or STOP, all state, counters and outputs SHALL remain frozen.
REQ-020 After a completed frame, a start bit already present on rx_s SHALL be accepted in the IDLE cycle immediately following.

Reset
REQ-021 On reset=1 at a clk edge, the FSM SHALL go to IDLE with s_cnt=0, n=0, b=0, dout=0, rx_done_tick=0 and frame_err=0, and both synchronizer flops SHALL be set to 1.
REQ-022 Reset SHALL take priority over s_tick and rx in every state; reset mid-frame SHALL discard the partial frame and produce no rx_done_tick.

Structure
REQ-023 State encodings (2-bit) and the defaults for NBIT_DATA_LEN and SB_TICK SHALL live in the shared UART include file used by uart_tx and the interface block.
REQ-024 The block SHALL have no sub-module; the baud generator is a separate sibling block, and the synchronizer SHALL be inline.

Verification (16 s_tick per bit, s_tick every 4 clk)
REQ-025 Send frame 0xA5 with 1 stop bit -> exactly one rx_done_tick pulse, dout=0xA5, frame_err=0.
REQ-026 Drive rx low for 3 s_tick, then high -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
REQ-027 Send 0x5A with the stop bit driven low -> rx_done_tick pulses, dout=0x5A, frame_err=1.
REQ-028 Assert reset after 4 data bits of 0xFF, then send 0x3C -> outputs 0 during reset, no pulse for the aborted frame, then dout=0x3C.
REQ-029 Send 0x00 and 0xFF back to back with no idle gap -> two pulses, dout=0x00 then 0xFF, frame_err=0 for both.
REQ-030 Stop s_tick for 100 clk in mid-DATA, then resume -> frame still decoded correctly.
